id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Instruction-decode stage directly downstream of instruction fetch. Captures
//  {instr, pc} from IF in the IF/ID pipeline register. Decodes R-type ALU,
//  I-type ALU and LW instructions, and reads a 32x32 register file that
//  includes a write-back port. All outputs are registered and feed the execute
//  stage. Supports stall (hold) and flush (bubble).
// PARAMETERS
//  XLEN      32   datapath / register width
//  NREGS     32   register count (index width = 5)
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  if_instr     in   32    instruction from fetch
//  if_pc        in   32    PC of if_instr
//  if_valid     in   1     if_instr/if_pc valid this cycle
//  stall        in   1     hold ID register contents (hazard unit)
//  flush        in   1     kill instruction entering ID (branch redirect)
//  wb_we        in   1     register-file write enable
//  wb_rd        in   5     write-back destination index
//  wb_data      in   32    write-back data
//  id_valid     out  1     ID outputs hold a live instruction
//  id_pc        out  32    PC of decoded instruction
//  id_rs1       out  5     instr[19:15]
//  id_rs2       out  5     instr[24:20]
//  id_rd        out  5     instr[11:7]
//  id_rs1_data  out  32    rs1 operand value
//  id_rs2_data  out  32    rs2 operand value
//  id_imm       out  32    sign-extended instr[31:20] (I-type/LW), else 0
//  id_alu_op    out  4     {instr[30] if R-type else 0, funct3}
//  id_is_load   out  1     LW (opcode 0000011, funct3 010)
//  id_use_imm   out  1     ALU operand B is id_imm (I-type ALU or LW)
//  id_reg_we    out  1     instruction writes rd (legal, rd != 0)
//  id_illegal   out  1     valid instr with unsupported opcode/funct
// BEHAVIOUR
//  - Reset (reset_n=0, async): every output 0; all 32 registers cleared to 0.
//  - Latency: instruction at IF inputs at edge N appears on id_* after edge N.
//  - Per edge, priority: flush > stall > load.
//    flush=1: id_valid<=0. Other outputs are don't-care but stable; stall ignored.
//    stall=1: all id_* hold, except for the operand refresh rule below.
//    else: id_valid<=if_valid. Decoded fields load from if_instr/if_pc.
//  - Decode rules:
//    R-type (0110011): legal only if funct7 is 0000000 or 0100000;
//      funct7=0100000 is legal only with funct3=000 or 101.
//    I-type ALU (0010011): legal; use_imm=1.
//    LW: legal; is_load=1, use_imm=1.
//    Other opcode, or LOAD with funct3!=010: illegal=1, reg_we=0, is_load=0.
//    illegal, reg_we and is_load are forced to 0 when the captured if_valid=0.
//  - Register file read: combinational on if_instr fields, captured at the edge.
//    Index 0 always reads 0.
//    Write-through bypass: if wb_we && wb_rd==rs && rs!=0, the captured value
//    is wb_data, not the stale array value.
//  - Register file write at edge when wb_we && wb_rd!=0. Writes to x0 dropped.
//    Writes occur regardless of stall or flush.
//  - Operand refresh while stalled: if stall && !flush && id_valid && wb_we
//    && wb_rd==id_rsN && id_rsN!=0, then id_rsN_data<=wb_data. rs1 and rs2
//    are refreshed independently; both update if they match.
//  - reset_n deasserted mid-stream: pipeline contents are lost and
//    id_valid=0 until the first valid load after release.
// TESTING
//  1. Reset, regs x2=5, x3=7 via wb; if_instr=32'h003100B3 (add x1,x2,x3),
//     pc=0 -> next cycle id_valid=1, rs1_data=5, rs2_data=7, rd=1,
//     alu_op=4'b0000, reg_we=1.
//  2. if_instr=32'h40508233 (sub x4,x1,x5) with same-edge wb x5=9 ->
//     rs2_data=9 (bypass), alu_op=4'b1000.
//  3. if_instr=32'h0003A303 (lw x6,0(x7)), x7=0x100 -> is_load=1,
//     use_imm=1, imm=0, rs1_data=0x100.
//  4. stall=1 for 3 cycles with new if_instr; wb x2=0xAA during stall ->
//     id_pc/rd held, id_rs1_data becomes 0xAA.
//  5. flush=1 together with stall=1 -> id_valid=0 next cycle.
//     wb to x0 -> x0 still reads 0.
//  6. if_instr=32'hFFFFFFFF, if_valid=1 -> id_illegal=1, reg_we=0.
//     reset_n pulse mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register, R/I/LW decoder and a
// 32-entry register file with write-through bypass and stall-time operand refresh.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                if_instr,
  input  logic [XLEN-1:0]            if_pc,
  input  logic                       if_valid,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       wb_we,
  input  logic [$clog2(NREGS)-1:0]   wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_pc,
  output logic [$clog2(NREGS)-1:0]   id_rs1,
  output logic [$clog2(NREGS)-1:0]   id_rs2,
  output logic [$clog2(NREGS)-1:0]   id_rd,
  output logic [XLEN-1:0]            id_rs1_data,
  output logic [XLEN-1:0]            id_rs2_data,
  output logic [XLEN-1:0]            id_imm,
  output logic [3:0]                 id_alu_op,
  output logic                       id_is_load,
  output logic                       id_use_imm,
  output logic                       id_reg_we,
  output logic                       id_illegal
);

  localparam int RIDX = $clog2(NREGS);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RIDX-1:0] rs1_idx;
  logic [RIDX-1:0] rs2_idx;
  logic [RIDX-1:0] rd_idx;

  assign opcode  = if_instr[6:0];
  assign funct3  = if_instr[14:12];
  assign funct7  = if_instr[31:25];
  assign rs1_idx = RIDX'(if_instr[19:15]);
  assign rs2_idx = RIDX'(if_instr[24:20]);
  assign rd_idx  = RIDX'(if_instr[11:7]);

  logic [XLEN-1:0] regs [NREGS];

  // Write-back port; x0 is never written so it keeps its reset value of 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  logic            is_r;
  logic            is_i;
  logic            is_lw;
  logic            r_legal;
  logic            dec_legal;
  logic [3:0]      dec_alu_op;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_imm;
  logic            dec_is_load;
  logic            dec_illegal;
  logic            dec_reg_we;

  always_comb begin
    is_r        = (opcode == OP_R);
    is_i        = (opcode == OP_I);
    is_lw       = (opcode == OP_LOAD) && (funct3 == F3_LW);
    r_legal     = is_r && ((funct7 == F7_BASE) ||
                           ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
    dec_legal   = r_legal || is_i || is_lw;
    dec_alu_op  = {is_r & if_instr[30], funct3};
    dec_use_imm = is_i || is_lw;
    dec_imm     = '0;
    if (dec_use_imm) begin
      dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    end
    // A bubble entering ID must never look like a load, a writer or a trap.
    dec_is_load = if_valid && is_lw;
    dec_illegal = if_valid && !dec_legal;
    dec_reg_we  = if_valid && dec_legal && (rd_idx != '0);
  end

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // Same-edge write-back is forwarded so ID never captures a stale operand.
  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (rs1_idx == '0) begin
      rs1_val = '0;
    end else if (wb_we && (wb_rd == rs1_idx)) begin
      rs1_val = wb_data;
    end
    if (rs2_idx == '0) begin
      rs2_val = '0;
    end else if (wb_we && (wb_rd == rs2_idx)) begin
      rs2_val = wb_data;
    end
  end

  logic refresh_rs1;
  logic refresh_rs2;

  assign refresh_rs1 = id_valid && wb_we && (wb_rd == id_rs1) && (id_rs1 != '0);
  assign refresh_rs2 = id_valid && wb_we && (wb_rd == id_rs2) && (id_rs2 != '0);

  // IF/ID register: flush beats stall beats load. A stalled instruction keeps
  // tracking write-backs to its sources so it leaves ID with current operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_alu_op   <= '0;
      id_is_load  <= 1'b0;
      id_use_imm  <= 1'b0;
      id_reg_we   <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (flush) begin
      id_valid    <= 1'b0;
      id_is_load  <= 1'b0;
      id_reg_we   <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (stall) begin
      if (refresh_rs1) begin
        id_rs1_data <= wb_data;
      end
      if (refresh_rs2) begin
        id_rs2_data <= wb_data;
      end
    end else begin
      id_valid    <= if_valid;
      id_pc       <= if_pc;
      id_rs1      <= rs1_idx;
      id_rs2      <= rs2_idx;
      id_rd       <= rd_idx;
      id_rs1_data <= rs1_val;
      id_rs2_data <= rs2_val;
      id_imm      <= dec_imm;
      id_alu_op   <= dec_alu_op;
      id_is_load  <= dec_is_load;
      id_use_imm  <= dec_use_imm;
      id_reg_we   <= dec_reg_we;
      id_illegal  <= dec_illegal;
    end
  end

endmodule
